// File: rtl/half_subtractor_reg_if.sv
// rtl/half_subtractor_reg_if.sv - operand/result bundle for the registered half subtractor
//
// Purpose: carries the lane operands into half_subtractor_reg and the
// registered results back out.
// Signals:
//   A, B     [WIDTH]  minuend / subtrahend bits, one per lane
//   Vld_in            A/B are valid this cycle
//   Df, Bo   [WIDTH]  registered difference / borrow per lane
//   Vld_out           result registers hold a freshly captured result
//   Bo_any            registered OR of all borrow lanes
//   Bo_cnt   [CNT_W]  registered number of lanes with a borrow
// Modports: master drives operands (bench / upstream), slave is the subtractor.

interface half_subtractor_reg_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Vld_in;
  logic [WIDTH-1:0] Df;
  logic [WIDTH-1:0] Bo;
  logic             Vld_out;
  logic             Bo_any;
  logic [CNT_W-1:0] Bo_cnt;

  modport master (
    output A, B, Vld_in,
    input  Df, Bo, Vld_out, Bo_any, Bo_cnt
  );

  modport slave (
    input  A, B, Vld_in,
    output Df, Bo, Vld_out, Bo_any, Bo_cnt
  );
endinterface

// File: rtl/half_subtractor_reg.sv
// rtl/half_subtractor_reg.sv - registered bit-parallel half subtractor with borrow summary
//
// Purpose: WIDTH independent half-subtractor lanes (Df = A ^ B, Bo = ~A & B),
// no borrow ripple between lanes, results registered one cycle after Vld_in.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every output register
//   bus    half_subtractor_reg_if.slave: A, B, Vld_in in; Df, Bo, Vld_out,
//          Bo_any, Bo_cnt out

module half_subtractor_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  half_subtractor_reg_if.slave bus
);

  logic [WIDTH-1:0] d_comb;
  logic [WIDTH-1:0] b_comb;
  logic [CNT_W-1:0] cnt_comb;

  logic [WIDTH-1:0] df_q;
  logic [WIDTH-1:0] bo_q;
  logic             vld_q;
  logic             any_q;
  logic [CNT_W-1:0] cnt_q;

  // Per-lane logic; lanes never see each other's borrow.
  always_comb begin
    d_comb   = bus.A ^ bus.B;
    b_comb   = ~bus.A & bus.B;
    cnt_comb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_comb = cnt_comb + CNT_W'(b_comb[i]);
    end
  end

  // Data registers only load on Vld_in, so X on idle operands never reaches
  // the outputs; Vld_out simply tracks Vld_in one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      df_q  <= '0;
      bo_q  <= '0;
      vld_q <= 1'b0;
      any_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= bus.Vld_in;
      if (bus.Vld_in) begin
        df_q  <= d_comb;
        bo_q  <= b_comb;
        any_q <= |b_comb;
        cnt_q <= cnt_comb;
      end
    end
  end

  assign bus.Df      = df_q;
  assign bus.Bo      = bo_q;
  assign bus.Vld_out = vld_q;
  assign bus.Bo_any  = any_q;
  assign bus.Bo_cnt  = cnt_q;

endmodule

// File: tb/tb_half_subtractor_reg.sv
// tb/tb_half_subtractor_reg.sv - scoreboard bench for half_subtractor_reg at WIDTH=1 and WIDTH=4

module tb_half_subtractor_reg;

  typedef struct {
    logic [3:0] df;
    logic [3:0] bo;
    logic       vld;
    logic       any;
    logic [2:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q1[$];
  exp_t q4[$];
  exp_t m1;
  exp_t m4;

  half_subtractor_reg_if #(.WIDTH(1)) if1 ();
  half_subtractor_reg_if #(.WIDTH(4)) if4 ();

  half_subtractor_reg #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  half_subtractor_reg #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truth table per lane: returns {Df, Bo}.
  function automatic logic [1:0] hs(input logic a, input logic b);
    case ({a, b})
      2'b00:   hs = 2'b00;
      2'b01:   hs = 2'b11;
      2'b10:   hs = 2'b10;
      default: hs = 2'b00;
    endcase
  endfunction

  function automatic exp_t model_step(input exp_t cur, input logic [3:0] a,
                                      input logic [3:0] b, input logic v, input int w);
    exp_t       n;
    logic [1:0] r;
    n = cur;
    n.vld = v;
    if (v) begin
      n.df  = '0;
      n.bo  = '0;
      n.cnt = '0;
      for (int i = 0; i < w; i++) begin
        r = hs(a[i], b[i]);
        n.df[i] = r[1];
        n.bo[i] = r[0];
        n.cnt   = n.cnt + {2'b00, r[0]};
      end
      n.any = (n.cnt != 3'd0);
    end
    return n;
  endfunction

  task automatic check_outputs();
    exp_t e1;
    exp_t e4;
    e1 = q1.pop_front();
    e4 = q4.pop_front();
    check("w1_df",  64'(if1.Df),      64'(e1.df[0]));
    check("w1_bo",  64'(if1.Bo),      64'(e1.bo[0]));
    check("w1_vld", 64'(if1.Vld_out), 64'(e1.vld));
    check("w1_any", 64'(if1.Bo_any),  64'(e1.any));
    check("w1_cnt", 64'(if1.Bo_cnt),  64'(e1.cnt));
    check("w4_df",  64'(if4.Df),      64'(e4.df));
    check("w4_bo",  64'(if4.Bo),      64'(e4.bo));
    check("w4_vld", 64'(if4.Vld_out), 64'(e4.vld));
    check("w4_any", 64'(if4.Bo_any),  64'(e4.any));
    check("w4_cnt", 64'(if4.Bo_cnt),  64'(e4.cnt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_w1_df"},  64'(if1.Df),      64'd0);
    check({tag, "_w1_bo"},  64'(if1.Bo),      64'd0);
    check({tag, "_w1_vld"}, 64'(if1.Vld_out), 64'd0);
    check({tag, "_w1_any"}, 64'(if1.Bo_any),  64'd0);
    check({tag, "_w1_cnt"}, 64'(if1.Bo_cnt),  64'd0);
    check({tag, "_w4_df"},  64'(if4.Df),      64'd0);
    check({tag, "_w4_bo"},  64'(if4.Bo),      64'd0);
    check({tag, "_w4_vld"}, 64'(if4.Vld_out), 64'd0);
    check({tag, "_w4_any"}, 64'(if4.Bo_any),  64'd0);
    check({tag, "_w4_cnt"}, 64'(if4.Bo_cnt),  64'd0);
  endtask

  // Drive one cycle of stimulus, push the expected result, then compare
  // #1 after the capturing edge.
  task automatic cycle(input logic a1, input logic b1, input logic v1,
                       input logic [3:0] a4, input logic [3:0] b4, input logic v4);
    if1.A = a1;  if1.B = b1;  if1.Vld_in = v1;
    if4.A = a4;  if4.B = b4;  if4.Vld_in = v4;
    m1 = model_step(m1, {3'b000, a1}, {3'b000, b1}, v1, 1);
    m4 = model_step(m4, a4, b4, v4, 4);
    q1.push_back(m1);
    q4.push_back(m4);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rv;

    m1 = '{default: '0};
    m4 = '{default: '0};
    rst_n = 1'b0;
    if1.A = '0; if1.B = '0; if1.Vld_in = 1'b0;
    if4.A = '0; if4.B = '0; if4.Vld_in = 1'b0;

    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full truth table on WIDTH=1; lane-independence vectors on WIDTH=4.
    cycle(1'b0, 1'b0, 1'b1, 4'b0101, 4'b0011, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 4'b1010, 4'b1010, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1);

    // Hold: idle inputs change but outputs keep the last capture.
    cycle(1'b0, 1'b1, 1'b1, 4'b0110, 4'b1011, 1'b1);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0);
    repeat (2) cycle(1'bx, 1'bx, 1'b0, 4'bxxxx, 4'bxxxx, 1'b0);

    // Asynchronous reset between edges, then an in-flight capture discarded.
    cycle(1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    if1.A = 1'b0; if1.B = 1'b1; if1.Vld_in = 1'b1;
    if4.A = 4'b0000; if4.B = 4'b1111; if4.Vld_in = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    m1 = '{default: '0};
    m4 = '{default: '0};
    cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 4'b0101, 4'b0011, 1'b1);

    // Back-to-back full-throughput stream.
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      cycle(ra[0], rb[0], 1'b1, ra, rb, 1'b1);
    end

    // Mixed valid/idle traffic.
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rv = 1'($urandom);
      cycle(ra[1], rb[1], rv, ra, rb, ~rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
